// File: rtl/atsc_rs_pkg.sv
// rtl/atsc_rs_pkg.sv - shared constants, types and GF(256) helpers for the ATSC RS(207,187) encoder
package atsc_rs_pkg;

    localparam logic [8:0] GF_POLY  = 9'h11D;
    localparam int         N_DATA   = 187;
    localparam int         N_PARITY = 20;

    typedef enum logic {ST_DATA, ST_PARITY} state_t;

    typedef logic [N_PARITY-1:0][7:0] gen_t;

    function automatic logic [7:0] gf_mul_const(input logic [7:0] a, input logic [7:0] k,
                                                input logic [8:0] poly);
        logic [7:0] acc;
        logic [7:0] x;
        acc = 8'h00;
        x   = a;
        for (int i = 0; i < 8; i++) begin
            if (k[i]) acc = acc ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ poly[7:0]) : {x[6:0], 1'b0};
        end
        return acc;
    endfunction

    // Expands prod (x + alpha^i), i = 0..N_PARITY-1; the monic x^N_PARITY term is dropped.
    function automatic gen_t rs_gen_calc();
        logic [N_PARITY:0][7:0] g;
        logic [7:0]             root;
        gen_t                   r;
        g    = '0;
        g[0] = 8'h01;
        root = 8'h01;
        for (int i = 0; i < N_PARITY; i++) begin
            for (int j = N_PARITY; j > 0; j--) begin
                g[j] = g[j-1] ^ gf_mul_const(g[j], root, GF_POLY);
            end
            g[0] = gf_mul_const(g[0], root, GF_POLY);
            root = gf_mul_const(root, 8'h02, GF_POLY);
        end
        for (int j = 0; j < N_PARITY; j++) r[j] = g[j];
        return r;
    endfunction

    localparam gen_t RS_GEN = rs_gen_calc();

endpackage

// File: rtl/atsc_gf_mul.sv
// rtl/atsc_gf_mul.sv - multiply a byte by a fixed GF(256) constant (reduces to an XOR network)
module atsc_gf_mul
    import atsc_rs_pkg::*;
#(
    parameter logic [7:0] COEF = 8'h01,
    parameter logic [8:0] POLY = 9'h11D
) (
    input  logic [7:0] a_i,
    output logic [7:0] y_o
);

    always_comb begin
        y_o = gf_mul_const(a_i, COEF, POLY);
    end

endmodule

// File: rtl/atsc_rsenc.sv
// rtl/atsc_rsenc.sv - systematic RS(207,187) encoder: forwards 187 data bytes then 20 LFSR parity bytes
module atsc_rsenc #(
    parameter int N_DATA   = atsc_rs_pkg::N_DATA,
    parameter int N_PARITY = atsc_rs_pkg::N_PARITY
) (
    input  logic        ce_clk,
    input  logic        ce_rst,
    input  logic [31:0] in_tdata,
    input  logic        in_tvalid,
    output logic        in_tready,
    input  logic        in_tlast,
    output logic [31:0] out_tdata,
    output logic        out_tvalid,
    input  logic        out_tready,
    output logic        out_tlast,
    output logic        frame_err
);
    import atsc_rs_pkg::*;

    localparam logic [7:0] LAST_DATA = 8'(N_DATA - 1);
    localparam logic [7:0] LAST_PAR  = 8'(N_PARITY - 1);

    state_t                    state_q, state_d;
    logic [7:0]                cnt_q, cnt_d;
    logic [N_PARITY-1:0][7:0]  lfsr_q, lfsr_d;
    logic [N_PARITY-1:0][7:0]  prod;
    logic [7:0]                out_data_q, out_data_d;
    logic                      out_valid_q, out_valid_d;
    logic                      out_last_q, out_last_d;
    logic                      err_q, err_d;
    logic [7:0]                fb;
    logic                      out_free;
    logic                      accept;
    logic                      unused_hi;

    assign unused_hi = ^in_tdata[31:8];

    assign out_free  = !out_valid_q || out_tready;
    assign in_tready = (state_q == ST_DATA) && out_free;
    assign accept    = in_tvalid && in_tready;
    assign fb        = in_tdata[7:0] ^ lfsr_q[N_PARITY-1];

    for (genvar i = 0; i < N_PARITY; i++) begin : g_mul
        atsc_gf_mul #(
            .COEF (RS_GEN[i]),
            .POLY (GF_POLY)
        ) u_mul (
            .a_i (fb),
            .y_o (prod[i])
        );
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        lfsr_d      = lfsr_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_valid_d = out_valid_q && !out_tready;
        err_d       = err_q;

        if (state_q == ST_DATA) begin
            if (accept) begin
                lfsr_d[0] = prod[0];
                for (int i = 1; i < N_PARITY; i++) begin
                    lfsr_d[i] = lfsr_q[i-1] ^ prod[i];
                end
                out_data_d  = in_tdata[7:0];
                out_valid_d = 1'b1;
                out_last_d  = 1'b0;
                cnt_d       = cnt_q + 8'd1;
                // tlast is only checked; framing stays on the internal count.
                if (in_tlast != (cnt_q == LAST_DATA)) err_d = 1'b1;
                if (cnt_q == LAST_DATA) begin
                    cnt_d   = 8'd0;
                    state_d = ST_PARITY;
                end
            end
        end else if (out_free) begin
            out_data_d  = lfsr_q[N_PARITY-1];
            lfsr_d      = {lfsr_q[N_PARITY-2:0], 8'h00};
            out_valid_d = 1'b1;
            out_last_d  = 1'b0;
            cnt_d       = cnt_q + 8'd1;
            if (cnt_q == LAST_PAR) begin
                out_last_d = 1'b1;
                cnt_d      = 8'd0;
                state_d    = ST_DATA;
            end
        end

        if (!out_valid_d) out_last_d = 1'b0;
    end

    always_ff @(posedge ce_clk or posedge ce_rst) begin
        if (ce_rst) begin
            state_q     <= ST_DATA;
            cnt_q       <= 8'd0;
            lfsr_q      <= '0;
            out_data_q  <= 8'h00;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            lfsr_q      <= lfsr_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            err_q       <= err_d;
        end
    end

    assign out_tdata  = {24'h000000, out_data_q};
    assign out_tvalid = out_valid_q;
    assign out_tlast  = out_last_q;
    assign frame_err  = err_q;

endmodule

// File: tb/tb_atsc_rsenc.sv
// tb/tb_atsc_rsenc.sv - directed/table-driven bench for atsc_rsenc with a log-table RS reference
module tb_atsc_rsenc;

    logic        ce_clk = 1'b0;
    logic        ce_rst;
    logic [31:0] in_tdata;
    logic        in_tvalid;
    logic        in_tready;
    logic        in_tlast;
    logic [31:0] out_tdata;
    logic        out_tvalid;
    logic        out_tready;
    logic        out_tlast;
    logic        frame_err;

    always #5 ce_clk = ~ce_clk;

    atsc_rsenc dut (
        .ce_clk     (ce_clk),
        .ce_rst     (ce_rst),
        .in_tdata   (in_tdata),
        .in_tvalid  (in_tvalid),
        .in_tready  (in_tready),
        .in_tlast   (in_tlast),
        .out_tdata  (out_tdata),
        .out_tvalid (out_tvalid),
        .out_tready (out_tready),
        .out_tlast  (out_tlast),
        .frame_err  (frame_err)
    );

    int vectors    = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    int gexp [0:509];
    int glog [0:255];
    int gn   [0:20];

    function automatic int gmul(input int a, input int b);
        if (a == 0 || b == 0) return 0;
        return gexp[glog[a] + glog[b]];
    endfunction

    task automatic init_gf();
        int v;
        gexp[0] = 1;
        for (int i = 1; i < 255; i++) begin
            v = gexp[i-1] << 1;
            if ((v & 256) != 0) v = v ^ 285;
            gexp[i] = v;
        end
        for (int i = 255; i < 510; i++) gexp[i] = gexp[i-255];
        for (int i = 0; i < 256; i++) glog[i] = 0;
        for (int i = 0; i < 255; i++) glog[gexp[i]] = i;
        for (int j = 0; j < 21; j++) gn[j] = 0;
        gn[0] = 1;
        for (int i = 0; i < 20; i++) begin
            for (int j = 20; j > 0; j--) gn[j] = gn[j-1] ^ gmul(gn[j], gexp[i]);
            gn[0] = gmul(gn[0], gexp[i]);
        end
    endtask

    int msg [0:186];
    int cw  [0:206];

    // Polynomial long division of m(x)*x^20 by g(x); byte 0 is the highest degree.
    task automatic encode_ref();
        int r [0:206];
        int c;
        for (int k = 0; k < 207; k++) r[k] = (k < 187) ? msg[k] : 0;
        for (int k = 0; k < 187; k++) begin
            c = r[k];
            if (c != 0) for (int j = 1; j <= 20; j++) r[k+j] = r[k+j] ^ gmul(c, gn[20-j]);
        end
        for (int k = 0; k < 207; k++) cw[k] = (k < 187) ? msg[k] : r[k];
    endtask

    logic [7:0] in_bytes [$];
    bit         in_lasts [$];
    logic [7:0] exp_beats [$];
    logic [7:0] got [$];

    task automatic run(input int pattern, input int npkt, input int tlast_pos, input int gap_pct,
                       input int rdy_pct, input bit hold, input int abort_beat);
        int         sent, cyc, first_acc, last_cyc, hold_cnt, idx, s;
        bit         prev_stall, plast, chk_nobubble, hold_act;
        logic [7:0] pdata;
        logic [31:0] junk;
        in_bytes.delete(); in_lasts.delete(); exp_beats.delete(); got.delete();
        for (int p = 0; p < npkt; p++) begin
            for (int k = 0; k < 187; k++) begin
                if (pattern == 0)      msg[k] = 0;
                else if (pattern == 1) msg[k] = (k == 186) ? 1 : 0;
                else                   msg[k] = int'($urandom_range(255));
                in_bytes.push_back(8'(msg[k]));
                in_lasts.push_back(k == tlast_pos);
            end
            encode_ref();
            for (int k = 0; k < 207; k++) exp_beats.push_back(8'(cw[k]));
        end
        sent = 0; cyc = 0; first_acc = -1; last_cyc = -1; hold_cnt = 0;
        prev_stall = 0; plast = 0; pdata = 0; chk_nobubble = 0;
        while (got.size() < exp_beats.size() && cyc < 4000) begin
            @(negedge ce_clk);
            if (prev_stall)
                check("stall_hold", {out_tvalid, out_tlast, out_tdata}, {1'b1, plast, 24'h0, pdata});
            if (chk_nobubble) begin
                check("handoff_nobubble", out_tvalid, 1);
                chk_nobubble = 0;
            end
            junk = $urandom();
            if (sent < in_bytes.size() && int'($urandom_range(99)) >= gap_pct) begin
                in_tvalid = 1; in_tdata = {junk[31:8], in_bytes[sent]}; in_tlast = in_lasts[sent];
            end else begin
                in_tvalid = 0; in_tdata = 32'h0; in_tlast = 0;
            end
            out_tready = (int'($urandom_range(99)) < rdy_pct);
            hold_act = hold && out_tvalid && out_tlast && sent < in_bytes.size();
            if (hold_act) begin
                in_tvalid = 1; in_tdata = {junk[31:8], in_bytes[sent]}; in_tlast = in_lasts[sent];
                out_tready = (hold_cnt >= 3);
                hold_cnt++;
            end
            #1;
            if (abort_beat >= 0 && got.size() == abort_beat && out_tvalid) break;
            if (hold_act) begin
                if (!out_tready) check("handoff_blocked", in_tready, 0);
                else begin
                    check("handoff_accept", in_tready, 1);
                    chk_nobubble = 1;
                end
            end
            if (in_tvalid && in_tready) begin
                if (first_acc < 0) first_acc = cyc;
                sent++;
            end
            if (out_tvalid && out_tready) begin
                idx = got.size();
                check("beat_data", out_tdata, {24'h0, exp_beats[idx]});
                check("beat_last", out_tlast, (idx % 207) == 206);
                got.push_back(out_tdata[7:0]);
                if (out_tlast) begin
                    last_cyc = cyc;
                    hold_cnt = 0;
                end
            end
            prev_stall = out_tvalid && !out_tready;
            pdata = out_tdata[7:0];
            plast = out_tlast;
            cyc++;
        end
        in_tvalid = 0; in_tdata = 0; in_tlast = 0;
        if (abort_beat >= 0) return;
        check("beat_count", got.size(), exp_beats.size());
        check("bytes_sent", sent, in_bytes.size());
        if (pattern == 0 && gap_pct == 0 && rdy_pct == 100)
            check("zero_latency", last_cyc - first_acc, 207);
        if (pattern == 1 && got.size() >= 207)
            for (int j = 0; j < 20; j++) check("impulse_parity", got[187+j], gn[19-j]);
        for (int p = 0; p < npkt && got.size() >= 207*(p+1); p++)
            for (int i = 0; i < 20; i++) begin
                s = 0;
                for (int k = 0; k < 207; k++) s = gmul(s, gexp[i]) ^ int'(got[p*207+k]);
                check("syndrome", s, 0);
            end
    endtask

    typedef struct {
        string name;
        int    pattern;
        int    npkt;
        int    tlast_pos;
        int    gap_pct;
        int    rdy_pct;
        bit    hold;
        bit    exp_err;
    } vec_t;

    vec_t vt [6];

    initial begin
        vt[0] = '{"zero",           0, 1, 186,  0, 100, 1'b0, 1'b0};
        vt[1] = '{"impulse",        1, 1, 186,  0, 100, 1'b0, 1'b0};
        vt[2] = '{"rand_b2b_stall", 2, 3, 186, 30,  50, 1'b0, 1'b0};
        vt[3] = '{"handoff",        2, 2, 186,  0, 100, 1'b1, 1'b0};
        vt[4] = '{"tlast_early",    2, 1, 100,  0, 100, 1'b0, 1'b1};
        vt[5] = '{"err_sticky",     2, 1, 186, 20,  70, 1'b0, 1'b1};

        init_gf();
        ce_rst = 1; in_tvalid = 0; in_tdata = 0; in_tlast = 0; out_tready = 0;
        repeat (2) @(negedge ce_clk);
        check("rst_tvalid", out_tvalid, 0);
        check("rst_tdata", out_tdata, 0);
        check("rst_tlast", out_tlast, 0);
        check("rst_frame_err", frame_err, 0);
        ce_rst = 0;
        @(negedge ce_clk);
        #1 check("rst_in_tready", in_tready, 1);

        for (int v = 0; v < 6; v++) begin
            run(vt[v].pattern, vt[v].npkt, vt[v].tlast_pos, vt[v].gap_pct, vt[v].rdy_pct, vt[v].hold, -1);
            check({vt[v].name, "_frame_err"}, frame_err, vt[v].exp_err);
        end

        run(2, 1, 186, 0, 100, 1'b0, 192);
        #1 ce_rst = 1;
        #1;
        check("async_rst_tvalid", out_tvalid, 0);
        check("async_rst_tlast", out_tlast, 0);
        check("async_rst_frame_err", frame_err, 0);
        @(negedge ce_clk);
        ce_rst = 0; out_tready = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge ce_clk);
            #1 check("post_rst_idle", out_tvalid, 0);
        end
        check("post_rst_in_tready", in_tready, 1);
        run(2, 1, 186, 0, 100, 1'b0, -1);
        check("post_rst_frame_err", frame_err, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/atsc_rsenc.md
Name: atsc_rsenc

Overview:
- Transmit-side counterpart of the ATSC RS decoder: systematic Reed-Solomon (207,187) encoder over GF(256) with field polynomial x^8+x^4+x^3+x^2+1 and 20 parity bytes.
- Sits between the axi_wrapper m_axis/s_axis data ports of an RFNoC encoder block.
- Accepts 187-byte MPEG-TS packets as a byte stream, forwards the data bytes, then appends 20 parity bytes computed by a 20-stage GF(256) LFSR.

Parameters:
- N_DATA, 187, data bytes per codeword.
- N_PARITY, 20, parity bytes per codeword; also the LFSR depth. Must match the generator table in the package.

Ports:
- ce_clk  in  1  block clock.
- ce_rst  in  1  asynchronous, active-high reset.
- in_tdata  in  32  payload byte in [7:0]; [31:8] ignored.
- in_tvalid  in  1  input valid.
- in_tready  out  1  input ready.
- in_tlast  in  1  expected on data byte N_DATA-1; checked only.
- out_tdata  out  32  output byte in [7:0]; [31:8] always 0.
- out_tvalid  out  1  output valid.
- out_tready  in  1  output ready.
- out_tlast  out  1  high on byte 206, the last parity byte.
- frame_err  out  1  sticky error flag; cleared only by ce_rst.

Behaviour:
- Reset values:
  - out_tvalid=0, out_tdata=0, out_tlast=0, frame_err=0.
  - LFSR all 0, byte counter 0, state DATA.
  - in_tready=1 after reset release.
- Reset is asynchronous; assertion mid-codeword discards the partial codeword. No output beats appear until the next fresh packet.
- Handshake:
  - A beat transfers on tvalid&&tready.
  - out_tvalid/out_tdata/out_tlast must not change while out_tvalid=1 and out_tready=0.
- Output stage: a single register. Input accepted in cycle N appears at the output in cycle N+1 (latency 1).
- in_tready = (state==DATA) && (!out_tvalid || out_tready).
- DATA state:
  - On each accepted byte d: fb = d ^ lfsr[19].
  - lfsr[i] = lfsr[i-1] ^ gfmul(fb, G[i]) for i=1..19; lfsr[0] = gfmul(fb, G[0]).
  - The output register loads d. The counter increments.
  - On acceptance of byte N_DATA-1: counter clears, next state is PARITY.
- PARITY state:
  - in_tready=0.
  - Whenever the output register is empty or being drained, it loads lfsr[19] and the LFSR shifts up (lfsr[i]=lfsr[i-1], lfsr[0]=0). The counter increments.
  - The 20th parity load sets out_tlast=1. Counter and LFSR are then all 0 and state returns to DATA.
  - Parity byte order is highest-degree first.
- Throughput: 207 output beats per 187 input beats with no bubbles under continuous valid/ready. The first data byte of the next packet may be accepted in the same cycle the last parity byte drains.
- in_tlast checking:
  - in_tlast=1 on a byte other than N_DATA-1 sets frame_err.
  - in_tlast=0 on byte N_DATA-1 also sets frame_err.
  - Framing always follows the internal count; in_tlast never resyncs the counter.
- GF multiply by a constant is pure XOR logic; there are no multipliers or ROMs in the datapath.
- The counter is 8 bits wide and wraps only through the explicit clears above, never at 255.

Decomposition:
- Package atsc_rs_pkg holds:
  - GF_POLY = 9'h11D.
  - N_DATA/N_PARITY defaults.
  - RS_GEN[0:19]: coefficients of g(x) = prod_{i=0..19}(x - alpha^i), monic term omitted.
  - State enum {ST_DATA, ST_PARITY}.
  - A constant-multiply function gf_mul_const.
- One sub-module is natural: atsc_gf_mul (8-bit GF(256) multiplier, combinational, generic over field polynomial). It is instanced 20 times with RS_GEN constants.
- The RFNoC wrapper (noc_block_rsenc) is separate and out of scope. It sets payload_length to 207 bytes in the header modifier.

Test Plan:
- All-zero packet: 187 x 0x00, ready always 1 -> 207 x 0x00 out, out_tlast only on beat 206, frame_err=0, 207 cycles from first accept to last beat.
- Impulse: bytes 0..185 = 0x00, byte 186 = 0x01 -> outputs 187..206 equal RS_GEN[19] down to RS_GEN[0]. Also feed the codeword through a software RS(207,187) decoder: zero syndromes.
- Random packets, 3 back-to-back, random out_tready (50%) and in_tvalid gaps -> byte-exact match to the reference model, no dropped or duplicated beats, outputs stable while stalled.
- Framing error: in_tlast on byte 100 -> frame_err=1 and stays 1. Output still 207 bytes at the correct count boundary.
- Reset mid-parity: assert ce_rst asynchronously at parity byte 5 -> out_tvalid drops immediately with no clock edge. The next packet encodes identically to the all-zero-state reference.
- Boundary handoff: next packet's first byte is presented while the last parity beat is held by out_tready=0 -> in_tready=0 until that beat transfers, then accepted in the same cycle; the sequence continues with no bubble.
